// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state and flag types for the multi-cycle ALU.
// Also holds the helpers that decide which opcodes use the iterative datapath.
package alu_pkg;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_SLTU  = 4'b0110;
    localparam logic [3:0] ALU_SLL   = 4'b0111;
    localparam logic [3:0] ALU_SRL   = 4'b1000;
    localparam logic [3:0] ALU_SRA   = 4'b1001;
    localparam logic [3:0] ALU_MUL   = 4'b1010;
    localparam logic [3:0] ALU_MULHU = 4'b1011;
    localparam logic [3:0] ALU_DIVU  = 4'b1100;
    localparam logic [3:0] ALU_REMU  = 4'b1101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic overflow;
        logic carry;
        logic negative;
        logic zero;
    } flags_t;

    function automatic logic is_iter_op(input logic [3:0] op);
        return op inside {ALU_MUL, ALU_MULHU, ALU_DIVU, ALU_REMU};
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return op inside {ALU_DIVU, ALU_REMU};
    endfunction

    // MULHU and REMU take the upper half of the accumulator.
    function automatic logic sel_high_half(input logic [3:0] op);
        return op inside {ALU_MULHU, ALU_REMU};
    endfunction

endpackage

// File: rtl/alu_iter_md.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per cycle.
// A single WIDTH-bit adder/subtractor serves both; {r_hi, r_lo} is the 2*WIDTH accumulator.
module alu_iter_md #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int SHW = $clog2(WIDTH);

    logic             r_busy;
    logic             r_is_div;
    logic [SHW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_b;

    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_y;
    logic [WIDTH:0]   w_sum;
    logic             w_ge;

    // Multiply adds B (or 0) to the high half; divide subtracts B from the
    // remainder shifted left by one with the next dividend bit.
    assign w_x   = r_is_div ? {r_hi[WIDTH-2:0], r_lo[WIDTH-1]} : r_hi;
    assign w_y   = (r_is_div || r_lo[0]) ? r_b : '0;
    assign w_sum = {1'b0, w_x} + {1'b0, r_is_div ? ~w_y : w_y} + {{WIDTH{1'b0}}, r_is_div};
    // The bit shifted out of the remainder makes the trial value at least 2^WIDTH > B.
    assign w_ge  = r_hi[WIDTH-1] | w_sum[WIDTH];

    // NOTE: o_hi/o_lo are the accumulator's next value, so the caller can
    // register the finished result on the same edge as the last iteration.
    always_comb begin
        if (r_is_div) begin
            o_hi = w_ge ? w_sum[WIDTH-1:0] : w_x;
            o_lo = {r_lo[WIDTH-2:0], w_ge};
        end else begin
            o_hi = w_sum[WIDTH:1];
            o_lo = {w_sum[0], r_lo[WIDTH-1:1]};
        end
    end

    assign o_done = r_busy && (r_cnt == SHW'(WIDTH - 1));

    // NOTE: reset is synchronous, so rst_n is tested inside the clocked block.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy   <= 1'b0;
            r_is_div <= 1'b0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
        end else if (i_start) begin
            r_busy   <= 1'b1;
            r_is_div <= i_is_div;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= i_a;
            r_b      <= i_b;
        end else if (r_busy) begin
            r_hi  <= o_hi;
            r_lo  <= o_lo;
            r_cnt <= r_cnt + SHW'(1);
            if (o_done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: FSM, single-cycle combinational unit and registered result/flags.
// MUL/MULHU/DIVU/REMU (with B != 0) are delegated to alu_iter_md.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             carry,
    output logic             negative,
    output logic             zero
);

    localparam int SHW = $clog2(WIDTH);

    state_t           r_state;
    logic             r_sel_hi;
    logic [WIDTH-1:0] r_result;
    flags_t           r_flags;

    logic             w_accept;
    logic             w_is_div;
    logic             w_go_iter;
    logic             w_start;
    logic             w_load;
    logic             w_iter_done;
    logic [WIDTH-1:0] w_iter_hi;
    logic [WIDTH-1:0] w_iter_lo;
    logic [SHW-1:0]   w_amt;
    logic             w_sub;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_sc_result;
    logic             w_sc_carry;
    logic             w_sc_ovf;
    logic [WIDTH-1:0] w_fin_result;
    flags_t           w_fin_flags;

    assign in_ready  = (r_state == S_IDLE) && rst_n;
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign overflow  = r_flags.overflow;
    assign carry     = r_flags.carry;
    assign negative  = r_flags.negative;
    assign zero      = r_flags.zero;

    // Divide by zero never iterates; it is answered by the single-cycle unit.
    assign w_accept  = in_valid && in_ready;
    assign w_is_div  = is_div_op(alu_control);
    assign w_go_iter = is_iter_op(alu_control) && !(w_is_div && (B == '0));
    assign w_start   = w_accept && w_go_iter;
    assign w_load    = (w_accept && !w_go_iter) || w_iter_done;

    alu_iter_md #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_start),
        .i_is_div (w_is_div),
        .i_a      (A),
        .i_b      (B),
        .o_done   (w_iter_done),
        .o_hi     (w_iter_hi),
        .o_lo     (w_iter_lo)
    );

    assign w_amt = B[SHW-1:0];
    assign w_sub = (alu_control == ALU_SUB);
    assign w_sum = {1'b0, A} + {1'b0, w_sub ? ~B : B} + {{WIDTH{1'b0}}, w_sub};

    // NOTE: every output gets a default first so no path infers a latch.
    always_comb begin
        w_sc_result = '0;
        w_sc_carry  = 1'b0;
        w_sc_ovf    = 1'b0;
        case (alu_control)
            ALU_ADD, ALU_SUB: begin
                w_sc_result = w_sum[WIDTH-1:0];
                w_sc_carry  = w_sum[WIDTH];
                w_sc_ovf    = ~(A[WIDTH-1] ^ B[WIDTH-1] ^ w_sub) & (A[WIDTH-1] ^ w_sum[WIDTH-1]);
            end
            ALU_AND:  w_sc_result = A & B;
            ALU_OR:   w_sc_result = A | B;
            ALU_XOR:  w_sc_result = A ^ B;
            ALU_SLT:  w_sc_result = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
            ALU_SLTU: w_sc_result = {{(WIDTH-1){1'b0}}, A < B};
            ALU_SLL:  w_sc_result = A << w_amt;
            ALU_SRL:  w_sc_result = A >> w_amt;
            ALU_SRA:  w_sc_result = $signed(A) >>> w_amt;
            ALU_DIVU: w_sc_result = '1;
            ALU_REMU: w_sc_result = A;
            default:  w_sc_result = '0;
        endcase
    end

    always_comb begin
        w_fin_flags = '0;
        if (w_iter_done) begin
            w_fin_result = r_sel_hi ? w_iter_hi : w_iter_lo;
        end else begin
            w_fin_result         = w_sc_result;
            w_fin_flags.carry    = w_sc_carry;
            w_fin_flags.overflow = w_sc_ovf;
        end
        w_fin_flags.negative = w_fin_result[WIDTH-1];
        w_fin_flags.zero     = (w_fin_result == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_sel_hi <= 1'b0;
            r_result <= '0;
            r_flags  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sel_hi <= sel_high_half(alu_control);
                        if (!w_go_iter) r_state <= S_DONE;
                        else            r_state <= w_is_div ? S_DIV : S_MUL;
                    end
                end
                S_MUL, S_DIV: begin
                    if (w_iter_done) r_state <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_load) begin
                r_result <= w_fin_result;
                r_flags  <= w_fin_flags;
            end
        end
    end

endmodule
